// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encoding and elaboration-time helpers for the
//               UART baud-tick generator.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Number of bits needed to hold the value (at least 1).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            v = v >> 1;
            n = n + 1;
        end
        return (n < 1) ? 1 : n;
    endfunction

    function automatic longint default_div(input longint clk_freq,
                                           input longint baud_rate,
                                           input longint osr);
        return clk_freq / (baud_rate * osr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : uart_prescaler
// Description : Clock prescaler producing a terminal-count strobe every D
//               cycles (D = max(div_int, 2)). With UART_BAUD_FRAC_EN defined a
//               fractional accumulator stretches selected periods by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prescaler
    import uart_pkg::*;
#(
    parameter int DIV_WD  = 16,
    parameter int FRAC_WD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               clear,
    input  logic [DIV_WD-1:0]  div_int,
    input  logic [FRAC_WD-1:0] div_frac,
    output logic               tc
);

    logic [DIV_WD-1:0] r_cnt;
    logic [DIV_WD-1:0] w_div;
    logic [DIV_WD-1:0] w_last;

    assign w_div = (div_int < DIV_WD'(2)) ? DIV_WD'(2) : div_int;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_WD-1:0] r_acc;
    logic               r_ext;
    logic [FRAC_WD:0]   w_sum;

    assign w_sum  = {1'b0, r_acc} + {1'b0, div_frac};
    // A carry from the previous period end lengthens this period by one.
    assign w_last = w_div - DIV_WD'(1) + DIV_WD'(r_ext);

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            r_acc <= '0;
            r_ext <= 1'b0;
        end else if (tc) begin
            r_acc <= w_sum[FRAC_WD-1:0];
            r_ext <= w_sum[FRAC_WD];
        end
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^div_frac;
    assign w_last        = w_div - DIV_WD'(1);
`endif

    assign tc = run && (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            r_cnt <= '0;
        end else if (tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_WD'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Baud-tick generator: oversample, bit and mid-bit ticks with a
//               run-time divisor, bit-aligned divisor updates and phase resync.
//               Optional fractional divisor enabled by UART_BAUD_FRAC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int OSR       = 16,
    parameter int DIV_WD    = 16,
    parameter int FRAC_WD   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_en,
    input  logic [DIV_WD-1:0]  div_int,
    input  logic [FRAC_WD-1:0] div_frac,
    input  logic               div_load,
    input  logic               resync,
    output logic               os_tick,
    output logic               bit_tick,
    output logic               mid_tick,
    output logic               active
);

    localparam int                  c_OSR_WD   = clogb2(OSR - 1);
    localparam logic [c_OSR_WD-1:0] c_OSR_LAST = c_OSR_WD'(OSR - 1);
    localparam logic [c_OSR_WD-1:0] c_OSR_MID  = c_OSR_WD'(OSR / 2 - 1);
    localparam logic [DIV_WD-1:0]   c_DEF_DIV  =
        DIV_WD'(default_div(CLK_FREQ, BAUD_RATE, OSR));

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_run;
    logic                r_active;
    logic [DIV_WD-1:0]   r_act_int;
    logic [FRAC_WD-1:0]  r_act_frac;
    logic [DIV_WD-1:0]   r_sh_int;
    logic [FRAC_WD-1:0]  r_sh_frac;
    logic                r_pend;
    logic                w_tc;
    logic                w_evt;
    logic                w_bit_evt;
    logic                w_mid_evt;
    logic [c_OSR_WD-1:0] r_osr;
    logic                r_os;
    logic                r_bit;
    logic                r_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (uart_en)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (!uart_en) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Counting only continues while RUN persists; a drop of uart_en clears phase.
    always_comb begin
        w_run = 1'b0;
        if (r_state == c_ST_RUN) begin
            w_run = uart_en;
        end
    end

    uart_prescaler #(
        .DIV_WD  (DIV_WD),
        .FRAC_WD (FRAC_WD)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (w_run),
        .clear    (resync),
        .div_int  (r_act_int),
        .div_frac (r_act_frac),
        .tc       (w_tc)
    );

    assign w_evt     = w_tc && !resync;
    assign w_bit_evt = w_evt && (r_osr == c_OSR_LAST);
    assign w_mid_evt = w_evt && (r_osr == c_OSR_MID);

    // In RUN the shadow only takes effect at a bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_int  <= c_DEF_DIV;
            r_act_frac <= '0;
            r_sh_int   <= c_DEF_DIV;
            r_sh_frac  <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (div_load) begin
                r_sh_int  <= div_int;
                r_sh_frac <= div_frac;
            end
            if (div_load && (r_state == c_ST_IDLE)) begin
                r_act_int  <= div_int;
                r_act_frac <= div_frac;
                r_pend     <= 1'b0;
            end else if (div_load) begin
                r_pend <= 1'b1;
            end else if (w_bit_evt && r_pend) begin
                r_act_int  <= r_sh_int;
                r_act_frac <= r_sh_frac;
                r_pend     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !w_run || resync) begin
            r_osr <= '0;
        end else if (w_evt) begin
            r_osr <= (r_osr == c_OSR_LAST) ? '0 : r_osr + c_OSR_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_os     <= 1'b0;
            r_bit    <= 1'b0;
            r_mid    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_os     <= w_evt;
            r_bit    <= w_bit_evt;
            r_mid    <= w_mid_evt;
            r_active <= (w_state_nxt == c_ST_RUN);
        end
    end

    assign os_tick  = r_os;
    assign bit_tick = r_bit;
    assign mid_tick = r_mid;
    assign active   = r_active;

endmodule
`default_nettype wire
